// File: rtl/vreg_pkg.sv
// Shared constants, element/vector types and the lane-merge helper for the
// multi-port vector register bank.
package vreg_pkg;

    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_LANES    = 4;
    localparam int DEF_ELEM_W   = 16;

    typedef logic [DEF_ELEM_W-1:0]   elem_t;
    typedef elem_t [DEF_LANES-1:0]   vector_t;

    // Per-lane select: new element where the mask bit is set, old element otherwise.
    function automatic vector_t lane_merge(input vector_t old_v,
                                           input vector_t new_v,
                                           input logic [DEF_LANES-1:0] mask);
        vector_t res_v;
        for (int i = 0; i < DEF_LANES; i++) begin
            res_v[i] = mask[i] ? new_v[i] : old_v[i];
        end
        return res_v;
    endfunction

endpackage

// File: rtl/vector_reg_bank_mp_read_port.sv
// One registered read port: address range check, same-cycle write bypass,
// hazard term and output flops.
module vreg_read_port
    import vreg_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int LANES    = DEF_LANES,
    parameter int ELEM_W   = DEF_ELEM_W,
    parameter int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    rd_en,
    input  logic [ADDR_W-1:0]                       rd_addr,
    input  logic                                    wr_en,
    input  logic [ADDR_W-1:0]                       wr_addr,
    input  logic [LANES-1:0]                        wr_mask,
    input  logic [LANES*ELEM_W-1:0]                 wr_data,
    input  logic [NUM_REGS-1:0][LANES*ELEM_W-1:0]   regs,
    input  logic [NUM_REGS-1:0]                     busy,
    output logic [LANES*ELEM_W-1:0]                 v,
    output logic                                    v_valid,
    output logic                                    hazard,
    output logic                                    addr_bad
);

    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    logic                      addr_ok_s;
    logic                      bypass_s;
    logic                      busy_sel_s;
    logic [LANES*ELEM_W-1:0]   stored_s;
    logic [LANES*ELEM_W-1:0]   merged_s;

    // Decode the stored word and busy bit by compare so no index can leave the array.
    always_comb begin
        stored_s   = '0;
        busy_sel_s = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            stored_s   = (rd_addr == ADDR_W'(i)) ? regs[i] : stored_s;
            busy_sel_s = (rd_addr == ADDR_W'(i)) ? busy[i] : busy_sel_s;
        end
    end

    // Range check, bypass detect and per-lane merge with the write in flight.
    always_comb begin
        addr_ok_s = ({1'b0, rd_addr} < NUM_REGS_L);
        bypass_s  = wr_en && (wr_addr == rd_addr) && addr_ok_s;
        addr_bad  = rd_en && !addr_ok_s;
        merged_s  = stored_s;
        for (int l = 0; l < LANES; l++) begin
            merged_s[l*ELEM_W +: ELEM_W] = (bypass_s && wr_mask[l]) ?
                wr_data[l*ELEM_W +: ELEM_W] : stored_s[l*ELEM_W +: ELEM_W];
        end
    end

    // Output registers; data holds when no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v       <= '0;
            v_valid <= 1'b0;
            hazard  <= 1'b0;
        end else if (rd_en) begin
            v       <= addr_ok_s ? merged_s : '0;
            v_valid <= 1'b1;
            hazard  <= addr_ok_s && busy_sel_s && !bypass_s;
        end else begin
            v_valid <= 1'b0;
            hazard  <= 1'b0;
        end
    end

endmodule

// File: rtl/vector_reg_bank_mp.sv
// Parametrised vector register bank: storage, masked write, busy scoreboard
// and two registered read ports.
module vector_reg_bank_mp
    import vreg_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int LANES    = DEF_LANES,
    parameter int ELEM_W   = DEF_ELEM_W,
    parameter int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rd_en_a,
    input  logic [ADDR_W-1:0]           rd_addr_a,
    input  logic                        rd_en_b,
    input  logic [ADDR_W-1:0]           rd_addr_b,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [LANES-1:0]            wr_mask,
    input  logic [LANES*ELEM_W-1:0]     wr_data,
    input  logic                        rsv_en,
    input  logic [ADDR_W-1:0]           rsv_addr,
    output logic [LANES*ELEM_W-1:0]     va,
    output logic [LANES*ELEM_W-1:0]     vb,
    output logic                        va_valid,
    output logic                        vb_valid,
    output logic                        hazard_a,
    output logic                        hazard_b,
    output logic                        addr_err,
    output logic [NUM_REGS-1:0]         busy
);

    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    logic [NUM_REGS-1:0][LANES*ELEM_W-1:0] regs_r;
    logic wr_ok_s;
    logic rsv_ok_s;
    logic bad_a_s;
    logic bad_b_s;
    logic bad_wr_s;
    logic bad_rsv_s;

    // Qualify write and reserve; out-of-range addresses never wrap onto a real register.
    always_comb begin
        wr_ok_s   = wr_en  && ({1'b0, wr_addr}  < NUM_REGS_L);
        rsv_ok_s  = rsv_en && ({1'b0, rsv_addr} < NUM_REGS_L);
        bad_wr_s  = wr_en  && !wr_ok_s;
        bad_rsv_s = rsv_en && !rsv_ok_s;
    end

    // Register storage with per-lane write mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_r <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wr_ok_s && (wr_addr == ADDR_W'(r)) && wr_mask[l]) begin
                        regs_r[r][l*ELEM_W +: ELEM_W] <= wr_data[l*ELEM_W +: ELEM_W];
                    end
                end
            end
        end
    end

    // Busy scoreboard: a same-cycle reserve beats the clearing write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rsv_ok_s && (rsv_addr == ADDR_W'(r))) begin
                    busy[r] <= 1'b1;
                end else if (wr_ok_s && (wr_addr == ADDR_W'(r))) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    // One-cycle pulse for any enabled access that missed the register range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= bad_a_s || bad_b_s || bad_wr_s || bad_rsv_s;
        end
    end

    vreg_read_port #(
        .NUM_REGS (NUM_REGS),
        .LANES    (LANES),
        .ELEM_W   (ELEM_W),
        .ADDR_W   (ADDR_W)
    ) u_port_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en_a),
        .rd_addr  (rd_addr_a),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_mask  (wr_mask),
        .wr_data  (wr_data),
        .regs     (regs_r),
        .busy     (busy),
        .v        (va),
        .v_valid  (va_valid),
        .hazard   (hazard_a),
        .addr_bad (bad_a_s)
    );

    vreg_read_port #(
        .NUM_REGS (NUM_REGS),
        .LANES    (LANES),
        .ELEM_W   (ELEM_W),
        .ADDR_W   (ADDR_W)
    ) u_port_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en_b),
        .rd_addr  (rd_addr_b),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_mask  (wr_mask),
        .wr_data  (wr_data),
        .regs     (regs_r),
        .busy     (busy),
        .v        (vb),
        .v_valid  (vb_valid),
        .hazard   (hazard_b),
        .addr_bad (bad_b_s)
    );

endmodule

// File: tb/tb_vector_reg_bank_mp.sv
// Directed and random stimulus for vector_reg_bank_mp, checked against an
// element-array reference model. Six registers so addresses 6 and 7 are out of range.
module tb_vector_reg_bank_mp;

    localparam int NR = 6;
    localparam int LN = 4;
    localparam int EW = 16;
    localparam int AW = 3;
    localparam int VW = LN * EW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en_a, rd_en_b, wr_en, rsv_en;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
    logic [LN-1:0] wr_mask;
    logic [VW-1:0] wr_data;
    logic [VW-1:0] va, vb;
    logic          va_valid, vb_valid, hazard_a, hazard_b, addr_err;
    logic [NR-1:0] busy;

    logic [EW-1:0] mregs [NR][LN];
    bit            mbusy [NR];
    logic [VW-1:0] exp_va, exp_vb;
    logic          exp_va_valid, exp_vb_valid, exp_ha, exp_hb, exp_err;

    int checks = 0;
    int passed = 0;

    vector_reg_bank_mp #(.NUM_REGS(NR), .LANES(LN), .ELEM_W(EW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .va(va), .vb(vb), .va_valid(va_valid), .vb_valid(vb_valid),
        .hazard_a(hazard_a), .hazard_b(hazard_b), .addr_err(addr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [NR-1:0] model_busy();
        logic [NR-1:0] b;
        for (int i = 0; i < NR; i++) b[i] = mbusy[i];
        return b;
    endfunction

    // What a read of address a returns this cycle, including the same-cycle write.
    function automatic logic [VW-1:0] model_read(input logic [AW-1:0] a);
        logic [VW-1:0] r;
        r = '0;
        if (int'(a) < NR) begin
            for (int l = 0; l < LN; l++) begin
                if (wr_en && wr_addr == a && wr_mask[l]) r[l*EW +: EW] = wr_data[l*EW +: EW];
                else r[l*EW +: EW] = mregs[int'(a)][l];
            end
        end
        return r;
    endfunction

    function automatic bit model_hazard(input logic [AW-1:0] a);
        if (int'(a) >= NR) return 1'b0;
        return mbusy[int'(a)] && !(wr_en && wr_addr == a);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            mbusy[r] = 1'b0;
            for (int l = 0; l < LN; l++) mregs[r][l] = '0;
        end
        exp_va = '0; exp_vb = '0;
        exp_va_valid = 1'b0; exp_vb_valid = 1'b0;
        exp_ha = 1'b0; exp_hb = 1'b0; exp_err = 1'b0;
    endtask

    task automatic idle();
        rd_en_a = 1'b0; rd_en_b = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; rsv_addr = '0;
        wr_mask = '0; wr_data = '0;
    endtask

    task automatic check_outputs();
        check("va", 64'(va), 64'(exp_va));
        check("vb", 64'(vb), 64'(exp_vb));
        check("va_valid", 64'(va_valid), 64'(exp_va_valid));
        check("vb_valid", 64'(vb_valid), 64'(exp_vb_valid));
        check("hazard_a", 64'(hazard_a), 64'(exp_ha));
        check("hazard_b", 64'(hazard_b), 64'(exp_hb));
        check("addr_err", 64'(addr_err), 64'(exp_err));
        check("busy", 64'(busy), 64'(model_busy()));
    endtask

    // Predict from the current inputs, advance the model, clock once, compare.
    task automatic cycle();
        if (rd_en_a) begin
            exp_va = model_read(rd_addr_a); exp_va_valid = 1'b1; exp_ha = model_hazard(rd_addr_a);
        end else begin
            exp_va_valid = 1'b0; exp_ha = 1'b0;
        end
        if (rd_en_b) begin
            exp_vb = model_read(rd_addr_b); exp_vb_valid = 1'b1; exp_hb = model_hazard(rd_addr_b);
        end else begin
            exp_vb_valid = 1'b0; exp_hb = 1'b0;
        end
        exp_err = (rd_en_a && int'(rd_addr_a) >= NR) || (rd_en_b && int'(rd_addr_b) >= NR) ||
                  (wr_en && int'(wr_addr) >= NR) || (rsv_en && int'(rsv_addr) >= NR);
        if (wr_en && int'(wr_addr) < NR) begin
            for (int l = 0; l < LN; l++)
                if (wr_mask[l]) mregs[int'(wr_addr)][l] = wr_data[l*EW +: EW];
            mbusy[int'(wr_addr)] = 1'b0;
        end
        if (rsv_en && int'(rsv_addr) < NR) mbusy[int'(rsv_addr)] = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state readable
        rd_en_a = 1'b1; rd_addr_a = 3'd3;
        cycle();
        check("t1_va", 64'(va), 64'h0);
        check("t1_valid", 64'(va_valid), 64'h1);

        // Full write then dual read
        idle(); wr_en = 1'b1; wr_addr = 3'd5; wr_mask = 4'hF; wr_data = 64'h0004_0003_0002_0001;
        cycle();
        idle(); rd_en_a = 1'b1; rd_addr_a = 3'd5; rd_en_b = 1'b1; rd_addr_b = 3'd5;
        cycle();
        check("t2_va", 64'(va), 64'h0004_0003_0002_0001);
        check("t2_vb", 64'(vb), 64'h0004_0003_0002_0001);

        // Masked write with same-cycle bypass
        idle(); wr_en = 1'b1; wr_addr = 3'd2; wr_mask = 4'hF; wr_data = 64'h1111_2222_3333_4444;
        cycle();
        idle(); wr_en = 1'b1; wr_addr = 3'd2; wr_mask = 4'b0101; wr_data = 64'hAAAA_BBBB_CCCC_DDDD;
        rd_en_a = 1'b1; rd_addr_a = 3'd2;
        cycle();
        check("t3_bypass", 64'(va), 64'h1111_BBBB_3333_DDDD);
        idle(); rd_en_b = 1'b1; rd_addr_b = 3'd2;
        cycle();
        check("t3_stored", 64'(vb), 64'h1111_BBBB_3333_DDDD);
        check("t3_va_hold", 64'(va), 64'h1111_BBBB_3333_DDDD);

        // Scoreboard on register 4
        idle(); rsv_en = 1'b1; rsv_addr = 3'd4;
        cycle();
        check("t4_busy_set", 64'(busy), 64'h10);
        idle(); rd_en_a = 1'b1; rd_addr_a = 3'd4;
        cycle();
        check("t4_hazard", 64'(hazard_a), 64'h1);
        idle(); rd_en_a = 1'b1; rd_addr_a = 3'd4; wr_en = 1'b1; wr_addr = 3'd4;
        wr_mask = 4'h0; wr_data = 64'h0;
        cycle();
        check("t4_resolved", 64'(hazard_a), 64'h0);
        check("t4_busy_clr", 64'(busy), 64'h0);
        idle(); rsv_en = 1'b1; rsv_addr = 3'd4; wr_en = 1'b1; wr_addr = 3'd4; wr_mask = 4'hF;
        wr_data = 64'h1234_5678_9ABC_DEF0;
        cycle();
        check("t4_rsv_wins", 64'(busy), 64'h10);

        // Out-of-range accesses
        idle(); wr_en = 1'b1; wr_addr = 3'd7; wr_mask = 4'hF; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle();
        check("t5_err", 64'(addr_err), 64'h1);
        idle(); rsv_en = 1'b1; rsv_addr = 3'd6;
        cycle();
        check("t5_rsv_oor_busy", 64'(busy), 64'h10);
        idle();
        cycle();
        check("t5_err_pulse", 64'(addr_err), 64'h0);
        idle(); rd_en_a = 1'b1; rd_addr_a = 3'd7; rd_en_b = 1'b1; rd_addr_b = 3'd6;
        cycle();
        check("t5_va", 64'(va), 64'h0);
        check("t5_hz", 64'(hazard_a), 64'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rd_en_a   = ($urandom_range(0, 3) != 0);
            rd_addr_a = AW'($urandom_range(0, 7));
            rd_en_b   = ($urandom_range(0, 3) != 0);
            rd_addr_b = AW'($urandom_range(0, 7));
            wr_en     = ($urandom_range(0, 1) != 0);
            wr_addr   = AW'($urandom_range(0, 7));
            wr_mask   = LN'($urandom_range(0, 15));
            wr_data   = {$urandom, $urandom};
            rsv_en    = ($urandom_range(0, 2) == 0);
            rsv_addr  = AW'($urandom_range(0, 7));
            if (n % 7 == 0) rd_addr_a = wr_addr;
            cycle();
        end

        // Asynchronous reset between edges during back-to-back writes
        for (int n = 0; n < 3; n++) begin
            idle(); wr_en = 1'b1; wr_addr = AW'(n); wr_mask = 4'hF; wr_data = {$urandom, $urandom};
            rsv_en = 1'b1; rsv_addr = AW'(n + 3); rd_en_a = 1'b1; rd_addr_a = AW'(n);
            cycle();
        end
        idle(); wr_en = 1'b1; wr_addr = 3'd1; wr_mask = 4'hF; wr_data = 64'hDEAD_BEEF_CAFE_F00D;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        for (int r = 0; r < NR; r += 2) begin
            idle(); rd_en_a = 1'b1; rd_addr_a = AW'(r); rd_en_b = 1'b1; rd_addr_b = AW'(r + 1);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vector_reg_bank_mp.md
Name: vector_reg_bank_mp

Overview:
Parametrised multi-port vector register bank. It replaces the fixed 8x64-bit bank: NUM_REGS registers, each LANES elements of ELEM_W bits. The block provides:
- two read ports with registered outputs;
- one write port with a per-lane write mask and write-to-read bypass;
- a per-register busy scoreboard, so the issue stage can detect read-after-write hazards against in-flight vector ops.

It sits between decode/issue and the vector ALU lanes.

Parameters:
- NUM_REGS, 8, number of vector registers (need not be a power of two).
- LANES, 4, elements per vector.
- ELEM_W, 16, bits per element. Default vector width is 64.
- ADDR_W, $clog2(NUM_REGS) (minimum 1), register address width. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_en_a  in  1  read request, port A.
- rd_addr_a  in  ADDR_W  read address, port A.
- rd_en_b  in  1  read request, port B.
- rd_addr_b  in  ADDR_W  read address, port B.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_mask  in  LANES  per-lane write enable; bit i covers element i.
- wr_data  in  LANES*ELEM_W  write vector; element i is bits [i*ELEM_W +: ELEM_W].
- rsv_en  in  1  reserve request: mark a register busy (destination of an issued op).
- rsv_addr  in  ADDR_W  register to reserve.
- va  out  LANES*ELEM_W  registered read data, port A.
- vb  out  LANES*ELEM_W  registered read data, port B.
- va_valid  out  1  va holds the result of the read requested in the previous cycle.
- vb_valid  out  1  vb holds the result of the read requested in the previous cycle.
- hazard_a  out  1  the port A read sampled last cycle targeted a busy register.
- hazard_b  out  1  the port B read sampled last cycle targeted a busy register.
- addr_err  out  1  registered pulse: an enabled access last cycle used an address >= NUM_REGS.
- busy  out  NUM_REGS  scoreboard vector, direct from flops.

Behaviour:
Reset:
- rst_n low, asynchronous: all registers, va, vb, va_valid, vb_valid, hazard_a, hazard_b, addr_err and busy go to 0.
- Reset asserted mid-operation discards any write, read or reserve in that cycle.
- First edge after rst_n rises behaves normally.

Write:
- At edge t with wr_en=1 and wr_addr<NUM_REGS, element i of reg[wr_addr] loads wr_data element i only where wr_mask[i]=1. Other lanes hold.
- wr_mask=0 is a legal no-op write; it still clears busy (see Scoreboard).

Read:
- Latency 1. Sampled at edge t, result appears on va/vb after edge t and is valid through cycle t+1.
- rd_en_x=1: x_valid=1 and vx=reg[rd_addr_x].
- rd_en_x=0: x_valid=0, hazard_x=0, vx holds its previous value.
- Ports A and B are independent. Both may read the same address.

Bypass:
- If a read and a write to the same valid address happen in the same cycle, the output is the per-lane merge: wr_data element where wr_mask=1, stored element otherwise.
- Read-after-write therefore never returns stale data.

Scoreboard:
- rsv_en=1 with a valid rsv_addr sets busy[rsv_addr] at the edge.
- A valid wr_en clears busy[wr_addr].
- Reserve and write to the same address in the same cycle: reserve wins, busy stays 1 (a new op has claimed the register).
- Reserve and write to different addresses apply independently.
- Reserving an already-busy register leaves it busy; no counting.

Hazard:
- hazard_x registers busy[rd_addr_x] & ~(wr_en & wr_addr==rd_addr_x) when rd_en_x=1.
- A same-cycle write resolves the hazard via bypass, even if a same-cycle reserve re-sets busy.

Address error:
- Any enabled access (read A, read B, write, reserve) with address >= NUM_REGS is ignored:
  - no state change;
  - the read returns all-zero data with valid=1 and hazard=0;
  - addr_err=1 for one cycle.
- An address never wraps.

Decomposition:
- Package vreg_pkg holds:
  - default parameter constants;
  - typedef elem_t, logic [ELEM_W-1:0];
  - vector_t, packed array [LANES] of elem_t;
  - function lane_merge(old, new, mask), which returns vector_t.
- One sub-module, vreg_read_port: address check, bypass merge, hazard term and output registers. Instantiated twice.
- Storage, write logic and scoreboard stay in the top.

Test Plan (defaults: NUM_REGS=8, LANES=4, ELEM_W=16):
1. Reset: hold rst_n=0, then release. All outputs and busy are 0; read reg 3 on A -> va=0, va_valid=1 one cycle later.
2. Write, then read: write reg5 = 0x0004_0003_0002_0001, mask 4'hF. Next cycle read A=5, B=5 -> va=vb=0x0004_0003_0002_0001 after one edge.
3. Masked write with bypass: reg2 holds 0x1111_2222_3333_4444. In the same cycle, write 0xAAAA_BBBB_CCCC_DDDD with mask 4'b0101 and read A=2 -> va=0x1111_BBBB_3333_DDDD; the stored value matches.
4. Scoreboard: rsv_en reg6 -> busy=8'h40. Read A=6 -> hazard_a=1. Write reg6 and read A=6 in the same cycle -> hazard_a=0, busy=0. Reserve and write reg6 in the same cycle -> busy[6] stays 1.
5. Out-of-range: set NUM_REGS=6 and write addr 7 (3-bit). No register changes, addr_err pulses once. Read A=7 -> va=0, va_valid=1, hazard_a=0.
6. Async reset mid-burst: assert rst_n low between edges during back-to-back writes. All outputs clear immediately without waiting for a clock edge, busy=0, and the registers read 0 after release.
